trashbin_mem_arbiter: RTL and testbench
=======================================

# trashbin_mem_arbiter

Parametrised memory arbiter and startup sequencer between one or more bus masters (CPU core, debug port, future DMA) and a single synchronous-read on-chip RAM. It holds all masters off for a programmable power-up interval, then grants round-robin, one transaction at a time. It drives the RAM address/write buses and returns read data with a per-master acknowledge. It generalises the fixed single-master controller and one-shot startup flag used in the current SoC top.

## Interface
- NUM_MASTERS, 2, number of requesting masters (1..8)
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 14, RAM word-address width; master addresses truncated to low ADDR_WIDTH bits
- READ_LATENCY, 1, RAM clock edges from address sample to valid DataReadBus (1..4)
- STARTUP_CYCLES, 2, cycles after reset before Ready rises (1..255)

- CoreClock  in  1  sole clock, all logic on rising edge
- CoreReset  in  1  synchronous, active-high reset
- Ready  out  1  startup interval complete, requests accepted
- MasterReq  in  NUM_MASTERS  per-master request, held until that master's Ack
- MasterWrite  in  NUM_MASTERS  1 = write, 0 = read; qualified by MasterReq
- MasterAddr  in  NUM_MASTERS*32  packed word addresses, master i at [32*i +: 32]
- MasterWData  in  NUM_MASTERS*DATA_WIDTH  packed write data
- MasterAck  out  NUM_MASTERS  one-cycle completion pulse, at most one bit set
- MasterRData  out  DATA_WIDTH  read data, valid only in the cycle the reader's Ack is high
- AddressBus  out  ADDR_WIDTH  RAM address
- DataWriteBus  out  DATA_WIDTH  RAM write data
- WriteAssert  out  1  RAM write enable
- DataReadBus  in  DATA_WIDTH  RAM read data
- GrantIndex  out  3  index of last granted master, debug

## Operation
- States: STARTUP, IDLE, ACCESS, READ_WAIT.
- Reset: STARTUP, startup counter 0, Ready 0, MasterAck 0, WriteAssert 0, AddressBus 0, DataWriteBus 0, MasterRData 0, GrantIndex NUM_MASTERS-1.
- STARTUP: counter increments each cycle. When it reaches STARTUP_CYCLES-1, go to IDLE and register Ready=1. Requests are ignored, with no Ack.
- IDLE: when any MasterReq is high, pick the first requester at or after (GrantIndex+1) mod NUM_MASTERS, wrapping. Register GrantIndex, AddressBus, DataWriteBus and WriteAssert=MasterWrite[i], then go to ACCESS. With no request, stay in IDLE and leave the buses unchanged except WriteAssert=0.
- ACCESS, write: MasterAck[i]=1 this cycle (registered at IDLE exit). WriteAssert is dropped on the next edge. Return to IDLE.
- ACCESS, read: WriteAssert=0. Load the latency counter and go to READ_WAIT.
- READ_WAIT: after READ_LATENCY edges, capture DataReadBus into MasterRData, pulse MasterAck[i] for one cycle, then return to IDLE.
- Masters drop MasterReq the cycle after their Ack. A Req still high in IDLE is a new transaction.
- Only one transaction is ever outstanding. Requests arriving mid-transaction wait.
- Reset asserted in any state aborts the transaction: no Ack, WriteAssert 0 the next cycle, full startup interval repeats.
- Ready stays 1 until the next reset.

## Timing
- Ready rises in cycle STARTUP_CYCLES after the reset-release cycle.
- Write: Req sampled high in IDLE cycle T gives WriteAssert and Ack high in T+1, and IDLE again in T+2. Back-to-back writes from different masters take 2 cycles each.
- Read: Req sampled in T, address on AddressBus during T+1, data captured, Ack and MasterRData valid in T+2+READ_LATENCY, IDLE in T+3+READ_LATENCY.
- Arbitration decision is combinational from MasterReq. All outputs are registered.
- Simultaneous requests from all masters are each served exactly once per round, in index order rotating from the last grant.

## Test plan
- Reset release with STARTUP_CYCLES=2 and MasterReq=1 held from cycle 0 -> Ready=0 in cycles 0-1, 1 in cycle 2; no Ack before cycle 3; first Ack to master 0.
- Master 0 writes 0xDEADBEEF to address 0x10, then reads 0x10 with READ_LATENCY=1 -> WriteAssert one cycle, write Ack at T+1; read Ack at T+3 with MasterRData=0xDEADBEEF.
- Masters 0 and 1 request continuously with NUM_MASTERS=2 -> Acks alternate 0,1,0,1 with no master granted twice in a row.
- Master 1 requests alone after a grant to master 1 -> master 1 granted again immediately; wrap-around leaves no idle cycle.
- Reset asserted during READ_WAIT -> no Ack, WriteAssert=0, Ready=0 the next cycle; full startup repeats; re-issued read returns correct data.
- Address 0xFFFF_C005 with ADDR_WIDTH=14 -> AddressBus=0x0005.

Source files
------------

// File: rtl/trashbin_mem_arbiter.sv
// trashbin_mem_arbiter: startup-gated round-robin arbiter from N masters onto one synchronous-read RAM
module trashbin_mem_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int STARTUP_CYCLES = 2
) (
  input  logic                            CoreClock,
  input  logic                            CoreReset,
  output logic                            Ready,
  input  logic [NUM_MASTERS-1:0]          MasterReq,
  input  logic [NUM_MASTERS-1:0]          MasterWrite,
  input  logic [NUM_MASTERS*32-1:0]       MasterAddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] MasterWData,
  output logic [NUM_MASTERS-1:0]          MasterAck,
  output logic [DATA_WIDTH-1:0]           MasterRData,
  output logic [ADDR_WIDTH-1:0]           AddressBus,
  output logic [DATA_WIDTH-1:0]           DataWriteBus,
  output logic                            WriteAssert,
  input  logic [DATA_WIDTH-1:0]           DataReadBus,
  output logic [2:0]                      GrantIndex
);
  typedef enum logic [1:0] {STARTUP, IDLE, ACCESS, READ_WAIT} state_t;
  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              lat_q, lat_d;
  logic                    ready_q, ready_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [2:0]              grant_q, grant_d;
  logic [2:0]              pick;
  logic [NUM_MASTERS-1:0]  pick_oh, grant_oh;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_wr;
  logic                    addr_unused;
  assign addr_unused = ^MasterAddr;
  // Smallest requester above the last grant wins; otherwise wrap to the smallest at or below it.
  always_comb begin
    pick = grant_q;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (MasterReq[i] && 3'(i) <= grant_q) pick = 3'(i);
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (MasterReq[i] && 3'(i) > grant_q) pick = 3'(i);
  end
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    pick_oh   = '0;
    grant_oh  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      pick_oh[i]  = 3'(i) == pick;
      grant_oh[i] = 3'(i) == grant_q;
      if (3'(i) == pick) begin
        sel_addr  = MasterAddr[32*i +: ADDR_WIDTH];
        sel_wdata = MasterWData[DATA_WIDTH*i +: DATA_WIDTH];
        sel_wr    = MasterWrite[i];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    ready_d = ready_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    grant_d = grant_q;
    case (state_q)
      STARTUP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(STARTUP_CYCLES - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: if (|MasterReq) begin
        grant_d = pick;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        we_d    = sel_wr;
        ack_d   = sel_wr ? pick_oh : '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        lat_d   = 3'(READ_LATENCY);
        state_d = we_q ? IDLE : READ_WAIT;
      end
      READ_WAIT: begin
        lat_d = lat_q == 3'd0 ? 3'd0 : lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          rdata_d = DataReadBus;
          ack_d   = grant_oh;
        end
        if (lat_q == 3'd0) state_d = IDLE;
      end
      default: state_d = STARTUP;
    endcase
  end
  always_ff @(posedge CoreClock) begin
    if (CoreReset) begin
      state_q <= STARTUP;
      cnt_q   <= '0;
      lat_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      grant_q <= 3'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      grant_q <= grant_d;
    end
  end
  assign Ready        = ready_q;
  assign MasterAck    = ack_q;
  assign MasterRData  = rdata_q;
  assign AddressBus   = addr_q;
  assign DataWriteBus = wdata_q;
  assign WriteAssert  = we_q;
  assign GrantIndex   = grant_q;
endmodule

// File: tb/tb_trashbin_mem_arbiter.sv
// tb_trashbin_mem_arbiter: directed stimulus with a scoreboard of expected acks checked by a monitor
module tb_trashbin_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        Ready;
  logic [1:0]  MasterReq, MasterWrite, MasterAck;
  logic [63:0] MasterAddr, MasterWData;
  logic [31:0] MasterRData, DataWriteBus, DataReadBus;
  logic [13:0] AddressBus;
  logic        WriteAssert;
  logic [2:0]  GrantIndex;
  int checks = 0;
  int errors = 0;
  typedef struct { int m; bit rd; logic [31:0] d; } exp_t;
  exp_t sb[$];
  logic [31:0] mem [0:16383];
  logic [31:0] rd_q;

  trashbin_mem_arbiter dut (
    .CoreClock(clk), .CoreReset(rst), .Ready(Ready),
    .MasterReq(MasterReq), .MasterWrite(MasterWrite), .MasterAddr(MasterAddr),
    .MasterWData(MasterWData), .MasterAck(MasterAck), .MasterRData(MasterRData),
    .AddressBus(AddressBus), .DataWriteBus(DataWriteBus), .WriteAssert(WriteAssert),
    .DataReadBus(DataReadBus), .GrantIndex(GrantIndex)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (WriteAssert) mem[AddressBus] <= DataWriteBus;
    rd_q <= mem[AddressBus];
  end
  assign DataReadBus = rd_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_ack(input int m, input bit rd, input logic [31:0] d);
    exp_t e;
    e.m = m; e.rd = rd; e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (MasterAck != 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got 0x%08h expected none", {30'b0, MasterAck});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_master", {30'b0, MasterAck}, 32'(1 << e.m));
        if (e.rd) chk("rdata", MasterRData, e.d);
      end
    end
  end

  task automatic master_txn(input int m, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input int exp_lat, input bit settle);
    int n;
    bit got;
    MasterAddr[32*m +: 32]  = addr;
    MasterWData[32*m +: 32] = data;
    MasterWrite[m] = wr;
    MasterReq[m]   = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (MasterAck[m]) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: master %0d got no ack within 40 cycles, required one", m);
    end else begin
      if (exp_lat >= 0) chk("ack_latency", n, exp_lat);
      if (wr) begin
        chk("write_assert", {31'b0, WriteAssert}, 1);
        chk("address_bus", {18'b0, AddressBus}, {18'b0, addr[13:0]});
        chk("write_data", DataWriteBus, data);
      end
    end
    MasterReq[m] = 1'b0;
    if (settle) begin
      @(posedge clk); #1;
      chk("write_assert_low", {31'b0, WriteAssert}, 0);
    end
  endtask

  task automatic startup_seq();
    rst = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      chk($sformatf("ready_cycle%0d", c), {31'b0, Ready}, 32'(c == 2));
      chk($sformatf("no_ack_cycle%0d", c), {30'b0, MasterAck}, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    MasterReq = '0; MasterWrite = '0; MasterAddr = '0; MasterWData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, Ready}, 0);
    chk("rst_ack", {30'b0, MasterAck}, 0);
    chk("rst_we", {31'b0, WriteAssert}, 0);
    chk("rst_addr", {18'b0, AddressBus}, 0);
    chk("rst_wdata", DataWriteBus, 0);
    chk("rst_rdata", MasterRData, 0);
    chk("rst_grant", {29'b0, GrantIndex}, 1);

    MasterWrite[0] = 1'b1;
    MasterAddr[31:0] = 32'h0;
    MasterWData[31:0] = 32'h0000_00A5;
    MasterReq[0] = 1'b1;
    expect_ack(0, 0, 0);
    startup_seq();
    @(posedge clk); #1;
    chk("first_ack_cycle3", {30'b0, MasterAck}, 1);
    MasterReq[0] = 1'b0;
    @(posedge clk); #1;

    expect_ack(0, 0, 0);
    master_txn(0, 1, 32'h10, 32'hDEAD_BEEF, 1, 1);
    expect_ack(0, 1, 32'hDEAD_BEEF);
    master_txn(0, 0, 32'h10, 32'h0, 3, 1);

    expect_ack(1, 0, 0);
    master_txn(1, 1, 32'hFFFF_C005, 32'h1234_5678, 1, 1);
    chk("grant_m1", {29'b0, GrantIndex}, 1);
    expect_ack(1, 0, 0);
    master_txn(1, 1, 32'h30, 32'hCAFE_F00D, 1, 0);
    chk("trunc_addr", {18'b0, AddressBus}, 32'h30);
    @(posedge clk); #1;

    expect_ack(0, 0, 0);
    expect_ack(1, 0, 0);
    expect_ack(0, 0, 0);
    expect_ack(1, 0, 0);
    fork
      begin
        master_txn(0, 1, 32'h20, 32'h1111_1111, -1, 0);
        master_txn(0, 1, 32'h22, 32'h3333_3333, -1, 1);
      end
      begin
        master_txn(1, 1, 32'h21, 32'h2222_2222, -1, 0);
        master_txn(1, 1, 32'h23, 32'h4444_4444, -1, 1);
      end
    join

    expect_ack(0, 1, 32'h2222_2222);
    master_txn(0, 0, 32'h21, 32'h0, 3, 1);
    expect_ack(1, 1, 32'h1234_5678);
    master_txn(1, 0, 32'h0000_0005, 32'h0, 3, 1);

    MasterWrite[0] = 1'b0;
    MasterAddr[31:0] = 32'h10;
    MasterReq[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    MasterReq[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_ack", {30'b0, MasterAck}, 0);
    chk("abort_we", {31'b0, WriteAssert}, 0);
    chk("abort_ready", {31'b0, Ready}, 0);
    @(posedge clk); #1;
    startup_seq();
    expect_ack(0, 1, 32'hDEAD_BEEF);
    master_txn(0, 0, 32'h10, 32'h0, 3, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required finish");
    $fatal(1, "watchdog");
  end
endmodule
